uart_rx_axis: RTL and testbench
===============================

# uart_rx_axis

UART receiver that deserialises 8N1 frames from the board `rxd` pin into bytes on an AXI-Stream master port. It complements the transmitter that drives `txd`. It sits between the `rxd` pad, which is currently tied high at chip level, and the UART FIFO / CPU-side logic. The block is clocked by the 125 MHz system clock and shares the same bit-period parameter as the transmit path.

## Interface
Parameters:
- `UART_BAUD`, default 434: clock cycles per bit period; legal range 4..65535.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `rxd`  in  1: asynchronous serial input; idles high.
- `m_axis_tdata`  out  8: received byte.
- `m_axis_tvalid`  out  1: byte available.
- `m_axis_tready`  in  1: downstream accepts byte.
- `busy`  out  1: high in any state other than IDLE.
- `frame_error`  out  1: one-cycle pulse when the stop bit is sampled low.
- `overrun_error`  out  1: one-cycle pulse when a completed byte is dropped.
- `parity_error`  out  1: one-cycle pulse on parity mismatch; constant 0 without `UART_RX_PARITY_EN`.

## Operation
Input synchronizer:
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.

Bit counter:
- Width is `$clog2(UART_BAUD)`. It is cleared on every state entry.

FSM states and transitions:
- IDLE: when `rxs`==0, go to START.
- START: at count == (`UART_BAUD`>>1)-1, sample `rxs`.
  - If 1, it was a glitch: return to IDLE with no output.
  - If 0, go to DATA with the bit index at 0.
- DATA: at count == `UART_BAUD`-1, sample `rxs` into the shift register, LSB first.
  - After bit 7, go to PARITY if the macro is defined, otherwise to STOP.
- PARITY: at count == `UART_BAUD`-1, sample the parity bit; even parity is checked.
- STOP: at count == `UART_BAUD`-1, sample `rxs`.
  - If 1, the byte completes: go to IDLE.
  - If 0, pulse `frame_error`, discard the byte, and go to BREAK.
- BREAK: wait for `rxs`==1, then go to IDLE. This covers line breaks and a stuck-low line.

Output register (single entry):
- On byte completion with `m_axis_tvalid`==0, or with `m_axis_tvalid`==1 and `m_axis_tready`==1 in the same cycle:
  - load `m_axis_tdata`;
  - set `m_axis_tvalid`.
- On byte completion with `m_axis_tvalid`==1 and `m_axis_tready`==0:
  - pulse `overrun_error`;
  - drop the new byte; the old byte is unchanged.
- `m_axis_tvalid` clears on handshake (`m_axis_tvalid`&&`m_axis_tready`) when no new byte completes in that cycle.
- `m_axis_tdata` is stable while `m_axis_tvalid` is high.

## Timing
Reset values:
- All outputs are 0 (`m_axis_tdata`=8'h00).
- FSM is in IDLE and the synchronizer flops are 1.
- A reset mid-frame discards the partial byte. Reception restarts only on the next falling edge after reset is released.

Sample points:
- Counted from the first cycle `rxs`==0, the start bit is sampled at +`UART_BAUD`/2 and data bit n at +`UART_BAUD`/2+(n+1)·`UART_BAUD`.
- Stop/parity sampling follows the same spacing.

Latency:
- `m_axis_tvalid` rises the cycle after the stop-bit sample.
- `rxd`→`rxs` adds 2 cycles.

Back-to-back frames:
- The return to IDLE occurs mid stop bit, so a start bit immediately after the stop bit is caught.

Error pulses:
- The error pulses are registered outputs, asserted the cycle after the offending sample.
- A byte with a parity error is discarded, not output. `frame_error` takes priority: with a low stop bit, only `frame_error` pulses.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1. The PARITY state is compiled in, `parity_error` is live, and mismatched bytes are dropped.
- Undefined: frame is 8N1. No PARITY state, and `parity_error` is tied 0.

## Test plan
All scenarios use `UART_BAUD`=8.
- Send 0x55 with `m_axis_tready`=1 → one `m_axis_tvalid` cycle with `m_axis_tdata`=0x55 and no error pulses.
- Hold `m_axis_tready`=0 and send 0xA5 then 0x3C back-to-back → `m_axis_tdata` holds 0xA5 and `overrun_error` pulses once. Raising `m_axis_tready` then produces one handshake of 0xA5 only.
- Drive `rxd` low for 3 cycles, then high → no `m_axis_tvalid`, no errors, `busy` returns to 0.
- Send a 0x00 frame with the stop bit low, then hold `rxd` low for 40 cycles → `frame_error` pulses once and `busy` stays 1 until `rxd` rises. A following 0x81 frame is received correctly.
- Assert `rst` during data bit 4 of 0xFF, release it, then send 0x12 → only 0x12 is output and all outputs read 0 during reset.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → `parity_error` pulse and no `m_axis_tvalid`. Send 0x07 with parity bit 1 → 0x07 is output.

Source files
------------

// File: rtl/uart_rx_axis_if.sv
// AXI-Stream byte channel carrying received UART bytes.
// master: the receiver driving tdata/tvalid; slave: the consumer driving tready.
interface uart_rx_axis_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/uart_rx_axis.sv
// UART receiver: deserialises frames from rxd into bytes on an AXI-Stream master.
// Default build receives 8N1. Defining UART_RX_PARITY_EN adds an even-parity bit
// (8E1), enables parity_error and drops bytes whose parity does not match.
// UART_BAUD is the number of clk cycles per bit period (4..65535).
module uart_rx_axis #(
  parameter int UART_BAUD = 434
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  uart_rx_axis_if.master   m_axis,
  output logic             busy,
  output logic             frame_error,
  output logic             overrun_error,
  output logic             parity_error
);

  localparam int CNT_W = (UART_BAUD > 1) ? $clog2(UART_BAUD) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(UART_BAUD - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((UART_BAUD >> 1) - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  logic             rxd_meta_q;
  logic             rxs_q;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             cnt_clr;
  logic             sample_full;

  logic             byte_done;
  logic             byte_accept;
  logic             stop_low;

  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
  logic             parity_bad_q, parity_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer for the asynchronous rxd pin; idles high out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
    end
  end

  assign sample_full = (cnt_q == CNT_FULL);

  // Frame FSM: start-bit qualification, LSB-first data shifting, optional parity and stop check
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    cnt_clr   = 1'b0;
    byte_done = 1'b0;
    stop_low  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          if (rxs_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (sample_full) begin
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            cnt_clr   = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_full) begin
          parity_bad_d = rxs_q ^ (^shift_q);
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sample_full) begin
          if (rxs_q) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_low = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit-period counter restarts on every state entry and between data bits
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_clr || (state_d != state_q)) begin
      cnt_d = '0;
    end
  end

  // A parity mismatch is only reported once the stop bit is good, so a framing error always wins
`ifdef UART_RX_PARITY_EN
  assign byte_accept  = byte_done && !parity_bad_q;
  assign parity_err_d = byte_done && parity_bad_q;
`else
  assign byte_accept  = byte_done;
`endif

  assign frame_err_d = stop_low;

  // Single-entry output register: load when empty or draining this cycle, otherwise flag overrun
  always_comb begin
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    overrun_d = 1'b0;
    if (tvalid_q && m_axis.tready) begin
      tvalid_d = 1'b0;
    end
    if (byte_accept) begin
      if (!tvalid_q || m_axis.tready) begin
        tvalid_d = 1'b1;
        tdata_d  = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, datapath and registered error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      tdata_q     <= 8'h00;
      tvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity tracking and its registered error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_error = parity_err_q;
`else
  assign parity_error = 1'b0;
`endif

  assign m_axis.tdata   = tdata_q;
  assign m_axis.tvalid  = tvalid_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_error    = frame_err_q;
  assign overrun_error  = overrun_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Testbench for uart_rx_axis with UART_BAUD=8. Stimulus pushes expected bytes into a
// scoreboard queue; a monitor pops and compares on every AXI-Stream handshake and
// counts error pulses, which the stimulus then checks per scenario.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_uart_rx_axis;
  localparam int BAUD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  logic busy, frame_error, overrun_error, parity_error;

  uart_rx_axis_if axis ();

  int nChecks = 0;
  int nFails = 0;
  int nHandshakes = 0;
  int nFrameErr = 0;
  int nOverrun = 0;
  int nParityErr = 0;
  logic [7:0] expQ[$];
  logic [7:0] prevData = 8'h00;
  logic prevHold = 1'b0;

  int hs0, fe0, ov0, pe0;

  always #5 clk = ~clk;

  uart_rx_axis #(.UART_BAUD(BAUD)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .m_axis        (axis),
    .busy          (busy),
    .frame_error   (frame_error),
    .overrun_error (overrun_error),
    .parity_error  (parity_error)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sampleNow();
    @(negedge clk);
  endtask

  // Drives one frame on rxd; rxd is left at the stop-bit level afterwards
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parityBit);
    rxd = 1'b0;
    waitCycles(BAUD);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      waitCycles(BAUD);
    end
`ifdef UART_RX_PARITY_EN
    rxd = parityBit;
    waitCycles(BAUD);
`endif
    rxd = stopBit;
    waitCycles(BAUD);
  endtask

  task automatic snapshot();
    hs0 = nHandshakes;
    fe0 = nFrameErr;
    ov0 = nOverrun;
    pe0 = nParityErr;
  endtask

  // Monitor: scoreboard compare on handshake, hold-stability check, error pulse counting
  always @(negedge clk) begin
    if (rst) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        nChecks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== prevData) begin
          nFails++;
          $display("[TB] FAIL hold_stable: tvalid=%0b tdata=0x%02h, expected tvalid=1 tdata=0x%02h",
                   axis.tvalid, axis.tdata, prevData);
        end
      end
      if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
        nHandshakes++;
        nChecks++;
        if (expQ.size() == 0) begin
          nFails++;
          $display("[TB] FAIL unexpected_byte: got 0x%02h, expected no output", axis.tdata);
        end else begin
          logic [7:0] exp;
          exp = expQ.pop_front();
          if (axis.tdata !== exp) begin
            nFails++;
            $display("[TB] FAIL byte_data: got 0x%02h, expected 0x%02h", axis.tdata, exp);
          end
        end
      end
      if (frame_error === 1'b1) nFrameErr++;
      if (overrun_error === 1'b1) nOverrun++;
      if (parity_error === 1'b1) nParityErr++;
      prevHold = (axis.tvalid === 1'b1) && (axis.tready !== 1'b1);
      prevData = axis.tdata;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    axis.tready = 1'b0;

    // Reset values
    #2;
    rst = 1'b1;
    waitCycles(2);
    sampleNow();
    checkOutput("reset_tvalid", axis.tvalid, 0);
    checkOutput("reset_tdata", axis.tdata, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_error", frame_error, 0);
    checkOutput("reset_overrun_error", overrun_error, 0);
    checkOutput("reset_parity_error", parity_error, 0);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(4);

    // 0x55 with tready high
    $display("[TB] scenario: single byte 0x55");
    axis.tready = 1'b1;
    snapshot();
    expQ.push_back(8'h55);
    applyStimulus(8'h55, 1'b1, ^8'h55);
    waitCycles(4);
    sampleNow();
    checkOutput("b55_handshakes", nHandshakes - hs0, 1);
    checkOutput("b55_frame_err", nFrameErr - fe0, 0);
    checkOutput("b55_overrun", nOverrun - ov0, 0);
    checkOutput("b55_parity_err", nParityErr - pe0, 0);
    checkOutput("b55_queue_empty", expQ.size(), 0);

    // Back-to-back 0xA5, 0x3C with tready low -> overrun, 0xA5 kept
    $display("[TB] scenario: overrun");
    waitCycles(1);
    axis.tready = 1'b0;
    snapshot();
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, ^8'hA5);
    applyStimulus(8'h3C, 1'b1, ^8'h3C);
    waitCycles(4);
    sampleNow();
    checkOutput("ovr_tvalid", axis.tvalid, 1);
    checkOutput("ovr_tdata", axis.tdata, 8'hA5);
    checkOutput("ovr_overrun", nOverrun - ov0, 1);
    checkOutput("ovr_handshakes_held", nHandshakes - hs0, 0);
    waitCycles(1);
    axis.tready = 1'b1;
    waitCycles(4);
    sampleNow();
    checkOutput("ovr_handshakes", nHandshakes - hs0, 1);
    checkOutput("ovr_tvalid_cleared", axis.tvalid, 0);
    checkOutput("ovr_queue_empty", expQ.size(), 0);

    // Short low glitch
    $display("[TB] scenario: glitch");
    waitCycles(BAUD);
    snapshot();
    rxd = 1'b0;
    waitCycles(3);
    rxd = 1'b1;
    waitCycles(1);
    sampleNow();
    checkOutput("glitch_busy_high", busy, 1);
    waitCycles(10);
    sampleNow();
    checkOutput("glitch_busy_low", busy, 0);
    checkOutput("glitch_handshakes", nHandshakes - hs0, 0);
    checkOutput("glitch_frame_err", nFrameErr - fe0, 0);
    checkOutput("glitch_overrun", nOverrun - ov0, 0);
    checkOutput("glitch_parity_err", nParityErr - pe0, 0);

    // Low stop bit followed by a held-low line, then 0x81
    $display("[TB] scenario: frame error and break");
    waitCycles(2);
    snapshot();
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitCycles(40);
    sampleNow();
    checkOutput("brk_frame_err", nFrameErr - fe0, 1);
    checkOutput("brk_busy_high", busy, 1);
    checkOutput("brk_handshakes", nHandshakes - hs0, 0);
    checkOutput("brk_parity_err", nParityErr - pe0, 0);
    waitCycles(1);
    rxd = 1'b1;
    waitCycles(4);
    sampleNow();
    checkOutput("brk_busy_low", busy, 0);
    waitCycles(BAUD);
    expQ.push_back(8'h81);
    applyStimulus(8'h81, 1'b1, ^8'h81);
    waitCycles(4);
    sampleNow();
    checkOutput("b81_handshakes", nHandshakes - hs0, 1);
    checkOutput("b81_frame_err", nFrameErr - fe0, 1);
    checkOutput("b81_queue_empty", expQ.size(), 0);

    // Reset during data bit 4 of 0xFF, then 0x12
    $display("[TB] scenario: mid-frame reset");
    waitCycles(2);
    snapshot();
    rxd = 1'b0;
    waitCycles(BAUD);
    rxd = 1'b1;
    waitCycles(4 * BAUD + BAUD / 2);
    rst = 1'b1;
    waitCycles(1);
    sampleNow();
    checkOutput("mrst_tvalid", axis.tvalid, 0);
    checkOutput("mrst_tdata", axis.tdata, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_errors", {frame_error, overrun_error, parity_error}, 0);
    waitCycles(3);
    rst = 1'b0;
    waitCycles(2 * BAUD);
    sampleNow();
    checkOutput("mrst_idle_after", busy, 0);
    waitCycles(1);
    expQ.push_back(8'h12);
    applyStimulus(8'h12, 1'b1, ^8'h12);
    waitCycles(4);
    sampleNow();
    checkOutput("b12_handshakes", nHandshakes - hs0, 1);
    checkOutput("b12_queue_empty", expQ.size(), 0);
    checkOutput("b12_frame_err", nFrameErr - fe0, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1
    $display("[TB] scenario: parity");
    waitCycles(2);
    snapshot();
    applyStimulus(8'h07, 1'b1, 1'b0);
    waitCycles(4);
    sampleNow();
    checkOutput("par_bad_pulse", nParityErr - pe0, 1);
    checkOutput("par_bad_handshakes", nHandshakes - hs0, 0);
    checkOutput("par_bad_frame_err", nFrameErr - fe0, 0);
    waitCycles(2);
    expQ.push_back(8'h07);
    applyStimulus(8'h07, 1'b1, 1'b1);
    waitCycles(4);
    sampleNow();
    checkOutput("par_good_handshakes", nHandshakes - hs0, 1);
    checkOutput("par_good_no_pulse", nParityErr - pe0, 1);
`endif

    checkOutput("final_queue_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
